// File: rtl/vga_sync_recover.sv
// vga_sync_recover: recovers hpos/vpos/visible and lock status from incoming active-high hsync/vsync
// Ports: clk pixel clock; reset async active-high; hsync_in/vsync_in source syncs;
// hpos/vpos recovered position (source position one cycle late); visible locked and in view;
// locked h_locked & v_locked; line_len last line period; frame_lines last frame line count;
// timing_err one-cycle pulse on a bad or lost period.
module vga_sync_recover #(
    parameter int H_VIEW     = 640,
    parameter int H_TOTAL    = 800,
    parameter int H_EDGE_POS = 657,
    parameter int V_VIEW     = 480,
    parameter int V_TOTAL    = 525,
    parameter int V_EDGE_POS = 490,
    parameter int LOCK_LINES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        visible,
    output logic        locked,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        timing_err
);
    localparam int G_W = $clog2(LOCK_LINES + 1);
    localparam logic [9:0]     H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]     H_LOAD = 10'(H_EDGE_POS);
    localparam logic [9:0]     H_VIS  = 10'(H_VIEW);
    localparam logic [9:0]     V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]     V_LOAD = 10'(V_EDGE_POS);
    localparam logic [9:0]     V_VIS  = 10'(V_VIEW);
    localparam logic [11:0]    H_LEN  = 12'(H_TOTAL);
    localparam logic [10:0]    V_LEN  = 11'(V_TOTAL);
    localparam logic [10:0]    L_MAX  = 11'(2 * V_TOTAL);
    localparam logic [G_W-1:0] G_MAX  = G_W'(LOCK_LINES);

    logic           hs_prev, vs_prev, seen_h, seen_v, h_locked, v_locked;
    logic [11:0]    hcnt;
    logic [10:0]    lcnt;
    logic [G_W-1:0] good;
    logic           hrise, vrise, h_bad, h_lost, v_bad;
    logic [10:0]    cap;
    logic [G_W-1:0] good_inc;

    // h_lost fires only on the transition into saturation, so a dead hsync pulses once
    always_comb begin
        hrise    = hsync_in & ~hs_prev;
        vrise    = vsync_in & ~vs_prev;
        h_bad    = hrise & seen_h & (hcnt != H_LEN);
        h_lost   = ~hrise & (hcnt == 12'd4094);
        cap      = (&lcnt) ? lcnt : lcnt + 11'(hrise);
        v_bad    = vrise & seen_v & (cap != V_LEN);
        good_inc = (good == G_MAX) ? good : good + G_W'(1);
    end

    assign visible = locked & (hpos < H_VIS) & (vpos < V_VIS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            hpos        <= '0;
            vpos        <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
            h_locked    <= 1'b0;
            v_locked    <= 1'b0;
            seen_h      <= 1'b0;
            seen_v      <= 1'b0;
            hcnt        <= '0;
            lcnt        <= '0;
            good        <= '0;
        end else begin
            hs_prev    <= hsync_in;
            vs_prev    <= vsync_in;
            hpos       <= hrise ? H_LOAD : (hpos == H_LAST) ? 10'd0 : hpos + 10'd1;
            vpos       <= vrise ? V_LOAD : (hpos != H_LAST) ? vpos : (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
            hcnt       <= hrise ? 12'd1 : (&hcnt) ? hcnt : hcnt + 12'd1;
            timing_err <= h_bad | h_lost | v_bad;
            locked     <= h_locked & v_locked;
            if (hrise) begin
                seen_h <= 1'b1;
                if (seen_h) begin
                    line_len <= hcnt;
                    good     <= h_bad ? '0 : good_inc;
                    h_locked <= ~h_bad & (good_inc == G_MAX);
                end
            end else if (h_lost) begin
                seen_h   <= 1'b0;
                h_locked <= 1'b0;
                good     <= '0;
            end
            if (vrise) begin
                lcnt        <= '0;
                frame_lines <= cap;
                seen_v      <= 1'b1;
                if (seen_v)
                    v_locked <= ~v_bad;
            end else begin
                if (hrise && !(&lcnt))
                    lcnt <= lcnt + 11'd1;
                if (lcnt > L_MAX) begin
                    v_locked <= 1'b0;
                    seen_v   <= 1'b0;
                end
            end
        end
    end
endmodule
